// File: rtl/input_unit_if.sv
// Board-side bundle for the input front end: raw buttons/switches in,
// captured word with valid/ack handshake and status out.
interface input_unit_if #(
  parameter int DATA_WIDTH = 16
);
  logic [2:0]            btn;
  logic [3:0]            sw;
  logic                  in_ack;
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic [2:0]            btn_level;
  logic                  overrun;

  // The input unit itself.
  modport slave (
    input  btn, sw, in_ack,
    output data, valid, btn_level, overrun
  );

  // Board and consumer side.
  modport master (
    output btn, sw, in_ack,
    input  data, valid, btn_level, overrun
  );
endinterface

// File: rtl/input_unit.sv
// Board-input front end: synchronises buttons/switches, debounces buttons,
// and captures the switch word on a btn[0] press under a valid/ack handshake.

module input_unit_db #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_WIDTH       = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_s_i,
  output logic st_o,
  output logic press_o
);
  logic                 st_q, st_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // A new level is accepted only after it has differed from the stable
  // level for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts it.
  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    press_o = 1'b0;
    if (btn_s_i == st_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_WIDTH'(DEBOUNCE_CYCLES - 1)) begin
      st_d    = btn_s_i;
      cnt_d   = '0;
      press_o = ~btn_s_i;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q  <= 1'b1;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  assign st_o = st_q;
endmodule

module input_unit #(
  parameter int DATA_WIDTH      = 16,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_WIDTH       = 20
) (
  input logic         clk,
  input logic         rst,
  input_unit_if.slave io
);
  typedef enum logic {IDLE, HOLD} state_t;

  logic [2:0] btn_m_q, btn_s_q;
  logic [3:0] sw_m_q, sw_s_q;
  logic [2:0] st, press;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  ovr_q, ovr_d;
  logic [DATA_WIDTH-1:0] sw_ext;

  // Two-flop synchronisers; buttons idle high (active-low) out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_m_q <= 3'b111;
      btn_s_q <= 3'b111;
      sw_m_q  <= 4'b0000;
      sw_s_q  <= 4'b0000;
    end else begin
      btn_m_q <= io.btn;
      btn_s_q <= btn_m_q;
      sw_m_q  <= io.sw;
      sw_s_q  <= sw_m_q;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_db
    input_unit_db #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_WIDTH       (CNT_WIDTH)
    ) u_db (
      .clk     (clk),
      .rst     (rst),
      .btn_s_i (btn_s_q[i]),
      .st_o    (st[i]),
      .press_o (press[i])
    );
  end

  assign sw_ext = {{(DATA_WIDTH-4){1'b0}}, sw_s_q};

  // Flush pre-empts everything; clear and capture are evaluated together,
  // with an overrun-setting capture taking precedence over clear.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ovr_d   = ovr_q;
    if (press[2]) begin
      state_d = IDLE;
    end else begin
      if (press[1]) ovr_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (press[0]) begin
            data_d  = sw_ext;
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (io.in_ack && press[0]) begin
            data_d = sw_ext;
          end else if (io.in_ack) begin
            state_d = IDLE;
          end else if (press[0]) begin
            ovr_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ovr_q   <= ovr_d;
    end
  end

  assign io.data      = data_q;
  assign io.valid     = (state_q == HOLD);
  assign io.btn_level = ~st;
  assign io.overrun   = ovr_q;
endmodule

// File: tb/tb_input_unit.sv
// Scoreboard bench for input_unit with a short debounce window.
module tb_input_unit;
  localparam int DW = 16;
  localparam int DB = 4;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [DW-1:0] exp_q[$];

  input_unit_if #(.DATA_WIDTH(DW)) io ();

  input_unit #(
    .DATA_WIDTH      (DW),
    .DEBOUNCE_CYCLES (DB),
    .CNT_WIDTH       (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input logic [DW-1:0] w);
    exp_q.push_back(w);
  endtask

  task automatic pop_check(input string tag);
    logic [DW-1:0] w;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      w = exp_q.pop_front();
      chk(tag, 32'(io.data), 32'(w));
    end
  endtask

  // Counts edges until valid rises, bounded by budget.
  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (!io.valid && n < budget) begin
      steps(1);
      n++;
    end
  endtask

  initial begin
    int n;
    bit glitch_ok;

    // 1. reset
    rst       = 1'b1;
    io.btn    = 3'b010;
    io.sw     = 4'hF;
    io.in_ack = 1'b1;
    steps(3);
    chk("rst_data",  32'(io.data), 32'h0);
    chk("rst_valid", 32'(io.valid), 32'h0);
    chk("rst_ovr",   32'(io.overrun), 32'h0);
    chk("rst_lvl",   32'(io.btn_level), 32'h0);
    io.btn    = 3'b111;
    io.in_ack = 1'b0;
    rst       = 1'b0;
    for (int c = 0; c < 20; c++) begin
      steps(1);
      chk("idle_valid", 32'(io.valid), 32'h0);
      chk("idle_lvl",   32'(io.btn_level), 32'h0);
    end
    chk("idle_data", 32'(io.data), 32'h0);
    chk("idle_ovr",  32'(io.overrun), 32'h0);

    // 2. capture and latency
    io.sw  = 4'b1010;
    io.btn = 3'b110;
    push_exp(16'h000A);
    wait_valid(20, n);
    chk("cap_latency", 32'(n), 32'(DB + 2));
    pop_check("cap_data");
    chk("cap_lvl", 32'(io.btn_level), 32'h1);
    io.in_ack = 1'b1;
    steps(1);
    io.in_ack = 1'b0;
    chk("ack_valid", 32'(io.valid), 32'h0);
    io.btn = 3'b111;
    n = 0;
    while (io.btn_level[0] && n < 20) begin
      steps(1);
      n++;
    end
    chk("rel_latency", 32'(n), 32'(DB + 2));
    chk("rel_valid", 32'(io.valid), 32'h0);
    steps(4);

    // 3. glitch rejection
    glitch_ok = 1'b1;
    for (int r = 0; r < 5; r++) begin
      io.btn = 3'b110;
      for (int c = 0; c < 3; c++) begin
        steps(1);
        if (io.valid || io.btn_level != 3'b000) glitch_ok = 1'b0;
      end
      io.btn = 3'b111;
      for (int c = 0; c < 4; c++) begin
        steps(1);
        if (io.valid || io.btn_level != 3'b000) glitch_ok = 1'b0;
      end
    end
    chk("glitch_quiet", 32'(glitch_ok), 32'h1);
    steps(4);
    chk("glitch_valid", 32'(io.valid), 32'h0);

    // 4. overrun set and clear
    io.sw  = 4'h3;
    io.btn = 3'b110;
    push_exp(16'h0003);
    wait_valid(20, n);
    chk("cap3_latency", 32'(n), 32'(DB + 2));
    pop_check("cap3_data");
    io.btn = 3'b111;
    steps(8);
    io.sw  = 4'h5;
    io.btn = 3'b110;
    steps(DB + 1);
    chk("ovr_early", 32'(io.overrun), 32'h0);
    steps(1);
    chk("ovr_set",   32'(io.overrun), 32'h1);
    chk("ovr_data",  32'(io.data), 32'h0003);
    chk("ovr_valid", 32'(io.valid), 32'h1);
    io.btn = 3'b111;
    steps(8);
    io.btn = 3'b101;
    steps(DB + 2);
    chk("clr_ovr",   32'(io.overrun), 32'h0);
    chk("clr_valid", 32'(io.valid), 32'h1);
    chk("clr_data",  32'(io.data), 32'h0003);
    io.btn = 3'b111;
    steps(8);

    // 5. same-cycle ack and capture
    io.sw  = 4'hC;
    io.btn = 3'b110;
    push_exp(16'h000C);
    steps(DB + 1);
    io.in_ack = 1'b1;
    chk("sc_pre_valid", 32'(io.valid), 32'h1);
    steps(1);
    io.in_ack = 1'b0;
    chk("sc_valid", 32'(io.valid), 32'h1);
    pop_check("sc_data");
    chk("sc_ovr", 32'(io.overrun), 32'h0);
    io.btn = 3'b111;
    steps(8);
    chk("sc_hold", 32'(io.valid), 32'h1);

    // 6. flush, then reset mid-debounce
    io.btn = 3'b011;
    steps(DB + 2);
    chk("fl_valid", 32'(io.valid), 32'h0);
    chk("fl_data",  32'(io.data), 32'h000C);
    chk("fl_lvl",   32'(io.btn_level), 32'h4);
    io.btn = 3'b111;
    steps(8);
    io.sw  = 4'h9;
    io.btn = 3'b110;
    steps(4);
    rst = 1'b1;
    #1;
    chk("mrst_data", 32'(io.data), 32'h0);
    chk("mrst_lvl",  32'(io.btn_level), 32'h0);
    steps(1);
    rst = 1'b0;
    push_exp(16'h0009);
    steps(DB + 1);
    chk("mrst_nocap", 32'(io.valid), 32'h0);
    steps(1);
    chk("mrst_cap", 32'(io.valid), 32'h1);
    pop_check("mrst_data2");
    io.btn = 3'b111;
    steps(4);

    chk("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/input_unit.md
Name: input_unit

Overview:
Board-input front end that feeds the CPU's `in` operand and sits directly upstream of the CPU core on the slowed clock domain.
- Synchronises and debounces the three push-buttons and synchronises the four data switches.
- On a debounced press of btn[0], captures the switches as a zero-extended DATA_WIDTH word and holds it under a valid/ack handshake until the CPU consumes it.
- Provides an overrun flag and two service buttons: clear-overrun and flush.

Parameters:
DATA_WIDTH, 16, width of `data`; must be >= 4.
DEBOUNCE_CYCLES, 500000, consecutive cycles a new button level must persist before acceptance; must be >= 2.
CNT_WIDTH, 20, debounce counter width; must satisfy 2^CNT_WIDTH > DEBOUNCE_CYCLES.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
btn  input  3  raw push-buttons, active-low (0 = pressed); asynchronous to clk.
sw  input  4  raw data switches; asynchronous to clk.
in_ack  input  1  consumer acknowledge; sampled high for one cycle means the word is taken.
data  output  DATA_WIDTH  captured word, {(DATA_WIDTH-4) zeros, sw[3:0]}.
valid  output  1  high while `data` holds an unconsumed word.
btn_level  output  3  debounced button levels, active-high (1 = pressed).
overrun  output  1  sticky flag: a capture press arrived while a word was still pending.

Behaviour:
- Reset (rst=1, asynchronous, overrides everything):
  - Sync flops: btn bits = 1, sw bits = 0.
  - Stable button levels = 1 (released); all debounce counters = 0.
  - FSM = IDLE; data = 0; valid = 0; overrun = 0; btn_level = 3'b000.
- Synchronisation: every btn and sw bit passes through a 2-flop synchroniser. sw_s is the synchronised switch value; switches are not debounced.
- Debounce, independently per button i (btn_s = synchronised value, st = stable value, cnt = counter):
  - If btn_s[i] == st[i]: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: st[i] <= btn_s[i] and cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles resets the count and is ignored.
- Events: press[i] is a one-cycle combinational strobe that is true in the cycle where st[i] will go 1->0 at the next edge. Releases generate no event.
- btn_level = ~st.
- Latency: a raw press is sampled at edge 1, and st and the FSM update at edge DEBOUNCE_CYCLES+2. `valid` is therefore high after exactly DEBOUNCE_CYCLES+2 rising edges.
- FSM states: IDLE (valid=0) and HOLD (valid=1). Per-cycle priority, highest first:
  1. press[2] (flush): go to IDLE, valid <= 0; data and overrun unchanged.
  2. press[1] (clear): overrun <= 0. This is evaluated together with rule 3; a press[0] in the same cycle is still handled normally.
  3. IDLE with press[0]: data <= zero-extended sw_s, go to HOLD.
  3. HOLD with in_ack and press[0] in the same cycle: the old word counts as consumed; data <= new sw_s; stay in HOLD; valid stays 1; no overrun.
  3. HOLD with in_ack only: go to IDLE; valid falls at the next edge.
  3. HOLD with press[0] only: overrun <= 1; data unchanged.
  3. in_ack while IDLE: ignored.
  - If press[1] and an overrun-setting press[0] occur in the same cycle, set wins (overrun = 1).
- data stays constant throughout HOLD except on a same-cycle ack+press.
- Reset asserted mid-debounce or in HOLD discards all state immediately.

Test Plan:
(All tests use DEBOUNCE_CYCLES=4.)
1. Reset: rst=1 with arbitrary inputs -> data=0, valid=0, overrun=0, btn_level=0; after rst=0 with btn=3'b111, outputs unchanged for 20 cycles.
2. Capture and latency: sw=4'b1010, btn[0] low from cycle 0 and held -> valid=1 and data=16'h000A after exactly 6 edges; in_ack pulsed one cycle -> valid=0 on the next edge; btn_level[0]=1 until release plus 6 edges.
3. Glitch rejection: btn[0] low for 3 cycles then high, repeated 5 times -> valid stays 0 and btn_level stays 0 throughout.
4. Overrun: capture sw=4'h3, no ack; change to sw=4'h5 and press btn[0] again -> overrun=1, data stays 16'h0003; press btn[1] -> overrun=0, valid still 1.
5. Same-cycle ack and capture: in HOLD with data=16'h0003, assert in_ack in the exact cycle press[0] fires with sw=4'hC -> valid remains 1 continuously, data=16'h000C, overrun=0.
6. Flush and reset mid-operation: in HOLD, press btn[2] -> valid=0 and data retained. Start a new btn[0] press, assert rst at debounce count 2 and then release it -> no capture occurs until a full new 6-edge press.
